pwm_dac_stage: RTL

PWM_DAC_STAGE -- requirements
Module: pwm_dac_stage

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_period_counter.sv | 35 +++
 rtl/pwm_dac_stage.sv | 99 +++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM DAC output stage.
package pwm_pkg;

    localparam int PWM_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_period_counter.sv
// Free-running PWM period counter; cleared while stopped, flags the last count of each period.
module pwm_period_counter
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = run && (cnt_q == {CNT_W{1'b1}});

endmodule

// File: rtl/pwm_dac_stage.sv
// PWM DAC output stage: samples an attenuated waveform once per period and modulates pwm_out.
module pwm_dac_stage
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       wave,
    input  logic [1:0]       amp,
    output logic             pwm_out,
    output logic             sample_tick,
    output logic [CNT_W-1:0] duty,
    output pwm_state_e       state_dbg
);

    pwm_state_e       state_q;
    pwm_state_e       state_d;
    logic [CNT_W-1:0] duty_q;
    logic [CNT_W-1:0] duty_d;
    logic             tick_q;
    logic             tick_d;

    logic             run;
    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic [7:0]       wave_shift;
    logic [CNT_W-1:0] atten;

    assign run = (state_q != ST_IDLE);

    pwm_period_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .cnt  (cnt),
        .wrap (wrap)
    );

    assign wave_shift = wave >> amp;
    assign atten      = CNT_W'(wave_shift);

    // wave/amp only reach duty on a latch edge: IDLE start or RUN period wrap.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                    duty_d  = atten;
                    tick_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (wrap) begin
                    duty_d = atten;
                    tick_d = 1'b1;
                end
                if (!en) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tick_q  <= tick_d;
        end
    end

    // Decoded from flops only so the RC filter never sees input glitches.
    assign pwm_out     = run && (cnt < duty_q);
    assign sample_tick = tick_q;
    assign duty        = duty_q;
    assign state_dbg   = state_q;

endmodule
